// File: rtl/instruction_mem.sv
// rtl/instruction_mem.sv - word-addressed instruction store with combinational fetch and synchronous program load
module instruction_mem #(
    parameter int          DEPTH    = 256,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    output logic [31:0] instruction,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        misaligned,
    output logic        out_of_range
);

    // Width of the word index; byte address bits [IDX_W+1:2] select the word.
    localparam int IDX_W = $clog2(DEPTH);

    // Reject geometries the index arithmetic below cannot represent.
    generate
        if ((DEPTH < 4) || (DEPTH > 4096) || ((1 << IDX_W) != DEPTH)) begin : g_bad_depth
            $error("instruction_mem: DEPTH must be a power of two between 4 and 4096");
        end
    endgenerate

    // Storage is a flat register array so that reset can clear every word in one edge.
    logic [31:0] mem_q [DEPTH];

    // Fetch-side decode.
    logic [IDX_W-1:0] rd_idx;
    logic             rd_oor;

    // Load-side decode.
    logic [IDX_W-1:0] wr_idx;
    logic             wr_oor;
    logic             wr_fire;

    // The two low byte-address bits of the load port carry no meaning for a word store.
    logic             unused_load_lsb;

    assign unused_load_lsb = ^load_addr[1:0];

    // Decode fetch and load addresses; any set bit above the index field is out of range,
    // so addresses near 2^32 never alias back into the array.
    always_comb begin
        rd_idx  = PC[IDX_W+1:2];
        rd_oor  = |PC[31:IDX_W+2];
        wr_idx  = load_addr[IDX_W+1:2];
        wr_oor  = |load_addr[31:IDX_W+2];
        wr_fire = load_en && !wr_oor;
    end

    // Combinational fetch: the word at the truncated index, or the NOP word when out of range.
    // No write bypass, so a same-index load only becomes visible after its clock edge.
    always_comb begin
        instruction  = NOP_WORD;
        misaligned   = (PC[1:0] != 2'b00);
        out_of_range = rd_oor;
        if (!rd_oor) begin
            instruction = mem_q[rd_idx];
        end
    end

    // Reset clears every word and discards a coincident load; otherwise an in-range load
    // updates one word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= NOP_WORD;
            end
        end else if (wr_fire) begin
            mem_q[wr_idx] <= load_data;
        end
    end

endmodule

// File: tb/tb_instruction_mem.sv
// tb/tb_instruction_mem.sv - directed self-checking bench for instruction_mem
module tb_instruction_mem;

    logic        clk;
    logic        reset;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        misaligned;
    logic        out_of_range;

    int checks;
    int errors;

    instruction_mem #(
        .DEPTH   (256),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PC          (PC),
        .instruction (instruction),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .misaligned  (misaligned),
        .out_of_range(out_of_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, actual, expected);
        end
    endtask

    // Present a fetch address and let the combinational path settle.
    task automatic fetch(input logic [31:0] addr);
        PC = addr;
        #1;
    endtask

    // One load cycle: drive on the falling edge, commit on the rising edge.
    task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        load_en   = 1'b0;
        load_addr = 32'h0;
        load_data = 32'h0;
        PC        = 32'h0;

        // Flags are purely combinational and valid before any reset.
        fetch(32'h0000_0006);
        check("pre_reset_misaligned", {31'b0, misaligned}, 32'd1);
        fetch(32'h0000_0400);
        check("pre_reset_oor", {31'b0, out_of_range}, 32'd1);

        // Reset for one cycle, then a few in-range reads return NOP.
        pulse_reset();
        fetch(32'h0000_0000);
        check("rst_pc0_instr", instruction, 32'h0);
        check("rst_pc0_mis", {31'b0, misaligned}, 32'd0);
        check("rst_pc0_oor", {31'b0, out_of_range}, 32'd0);
        fetch(32'h0000_0004);
        check("rst_pc4_instr", instruction, 32'h0);
        fetch(32'h0000_03FC);
        check("rst_pc1020_instr", instruction, 32'h0);
        check("rst_pc1020_oor", {31'b0, out_of_range}, 32'd0);

        // Program two words and read them back as PC changes.
        load_word(32'h0000_0000, 32'h2001_0005);
        load_word(32'h0000_0004, 32'h2002_000A);
        fetch(32'h0000_0000);
        check("ld_pc0", instruction, 32'h2001_0005);
        fetch(32'h0000_0004);
        check("ld_pc4", instruction, 32'h2002_000A);

        // Misaligned fetch still returns the word at the truncated index.
        fetch(32'h0000_0006);
        check("pc6_instr", instruction, 32'h2002_000A);
        check("pc6_mis", {31'b0, misaligned}, 32'd1);

        // First out-of-range word.
        fetch(32'h0000_0400);
        check("pc1024_instr", instruction, 32'h0);
        check("pc1024_oor", {31'b0, out_of_range}, 32'd1);

        // Out-of-range load must not alias onto word 0 or disturb anything else.
        load_word(32'h0000_0400, 32'hFFFF_FFFF);
        fetch(32'h0000_0000);
        check("oor_ld_pc0", instruction, 32'h2001_0005);
        fetch(32'h0000_0004);
        check("oor_ld_pc4", instruction, 32'h2002_000A);
        fetch(32'h0000_03FC);
        check("oor_ld_pc1020", instruction, 32'h0);

        // Read during write to the same index: old word before the edge, new after.
        @(negedge clk);
        PC        = 32'h0000_0008;
        load_en   = 1'b1;
        load_addr = 32'h0000_0008;
        load_data = 32'hDEAD_BEEF;
        #1;
        check("rdw_before", instruction, 32'h0);
        @(posedge clk);
        #1;
        load_en = 1'b0;
        check("rdw_after", instruction, 32'hDEAD_BEEF);

        // Back-to-back loads on consecutive cycles; last write to an index wins.
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = 32'h0000_0010;
        load_data = 32'hAAAA_0001;
        @(negedge clk);
        load_data = 32'hBBBB_0002;
        @(negedge clk);
        load_addr = 32'h0000_0014;
        load_data = 32'hCCCC_0003;
        @(negedge clk);
        load_en = 1'b0;
        fetch(32'h0000_0010);
        check("b2b_last_wins", instruction, 32'hBBBB_0002);
        fetch(32'h0000_0014);
        check("b2b_next", instruction, 32'hCCCC_0003);

        // Load address low bits are ignored: 0x1B targets word 6 (byte 0x18).
        load_word(32'h0000_001B, 32'h5555_AAAA);
        fetch(32'h0000_0018);
        check("ld_lsb_ignored", instruction, 32'h5555_AAAA);

        // Top of the address space is out of range, no wrap.
        fetch(32'hFFFF_FFFC);
        check("wrap_oor", {31'b0, out_of_range}, 32'd1);
        check("wrap_instr", instruction, 32'h0);
        check("wrap_mis", {31'b0, misaligned}, 32'd0);

        // Reset and load in the same cycle: the load is discarded and prior words are cleared.
        @(negedge clk);
        reset     = 1'b1;
        load_en   = 1'b1;
        load_addr = 32'h0000_000C;
        load_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        load_en = 1'b0;
        fetch(32'h0000_000C);
        check("rst_ld_pc12", instruction, 32'h0);
        fetch(32'h0000_0000);
        check("rst_ld_pc0", instruction, 32'h0);
        fetch(32'h0000_0008);
        check("rst_ld_pc8", instruction, 32'h0);
        fetch(32'h0000_0010);
        check("rst_ld_pc16", instruction, 32'h0);

        // Loading resumes normally after reset.
        load_word(32'h0000_0020, 32'h7777_0077);
        fetch(32'h0000_0020);
        check("post_rst_ld", instruction, 32'h7777_0077);
        fetch(32'h0000_03FC);
        check("last_word_ld_pre", instruction, 32'h0);
        load_word(32'h0000_03FC, 32'h0BAD_F00D);
        fetch(32'h0000_03FC);
        check("last_word_ld", instruction, 32'h0BAD_F00D);
        fetch(32'h0000_0000);
        check("last_word_no_alias", instruction, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
